// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder sequencer around one full-adder cell and a carry flop
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only has to reach WIDTH-1; for WIDTH >= 2 this is at least 1 bit.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [WIDTH-1:0] sumSh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bitSum;
  logic             bitCarry;
  logic             lastBit;
  logic             accept;
  logic             adding;

  // The single full-adder cell working on the current LSBs and the looped-back carry.
  assign bitSum   = aSh[0] ^ bSh[0] ^ carry;
  assign bitCarry = (carry & (aSh[0] ^ bSh[0])) | (aSh[0] & bSh[0]);
  assign lastBit  = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and state-decoded handshake outputs; inputs never reach the outputs directly.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    adding    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = ADD;
        end
      end
      ADD: begin
        busy   = 1'b1;
        adding = 1'b1;
        if (lastBit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture, one bit per cycle through the adder, and result load on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSh   <= '0;
      bSh   <= '0;
      sumSh <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      aSh   <= a;
      bSh   <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (adding) begin
      sumSh <= {bitSum, sumSh[WIDTH-1:1]};
      aSh   <= aSh >> 1;
      bSh   <= bSh >> 1;
      carry <= bitCarry;
      cnt   <= cnt + 1'b1;
      // The published result must include the bit produced on this same edge.
      if (lastBit) begin
        sum  <= {bitSum, sumSh[WIDTH-1:1]};
        cout <= bitCarry;
      end
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition bit-serially through a single full-adder cell, with one carry flip-flop closing the loop between cycles.
- Owns the operand shift registers, the bit counter and the start/busy/done handshake.
- Sits between a requester that supplies parallel operands and the 1-bit full-adder/DFF datapath.
- Trades WIDTH+1 cycles of latency for a single adder cell.

Parameters:
WIDTH  8  operand and result width in bits (legal range 2..32)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A; captured on an accepted start
b      input   WIDTH  operand B; captured on an accepted start
cin    input   1      carry-in; captured on an accepted start
busy   output  1      high in ADD and DONE
done   output  1      one-cycle pulse; sum/cout are valid while it is high
sum    output  WIDTH  registered result of the last completed operation
cout   output  1      registered carry-out of the last completed operation

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and counter are all cleared.
- States: IDLE, ADD, DONE. All outputs are registered or decoded from state only; none depends combinationally on the inputs.
- IDLE:
  - If start=1 at a clock edge: capture a into a_sh, b into b_sh, cin into carry. Clear cnt. Go to ADD.
  - Otherwise stay in IDLE.
- ADD (exactly WIDTH cycles). On each edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c = (carry & (a_sh[0] ^ b_sh[0])) | (a_sh[0] & b_sh[0]).
  - sum_sh shifts right, with s entering at bit WIDTH-1.
  - a_sh and b_sh shift right, with 0 filling.
  - carry <= c; cnt <= cnt+1.
  - When cnt = WIDTH-1 on that edge: load sum <= final sum_sh contents (including this edge's bit), load cout <= c, go to DONE.
  - cnt is wide enough to hold WIDTH-1. It never wraps during a valid operation.
- DONE (one cycle): done=1, busy=1. On the next edge go to IDLE.
- Latency: start accepted at edge E0 -> done high for the cycle following edge E0+WIDTH -> IDLE again after edge E0+WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- sum and cout change only on the completion edge and otherwise hold. A new operation does not disturb the previous result until it completes.
- Boundary conditions:
  - start while busy (ADD or DONE) is ignored: no queueing, no restart. a, b and cin are don't-care outside accepted-start edges.
  - start held high continuously: a new operation is accepted on each return to IDLE.
  - Overflow: the result is modulo 2^WIDTH, and cout carries the bit WIDTH carry.
  - Reset mid-operation aborts immediately. done is not pulsed, and sum/cout return to 0.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h05, cin=0, start pulsed for 1 cycle -> busy rises next cycle; done high exactly 9 cycles after the accepting edge; sum=8'h41, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Exhaustive sweep with WIDTH=4: all a, b, cin combinations (512 operations) checked against {cout,sum} = a+b+cin; every operation takes exactly 6 cycles from start to IDLE.
- Accept a=8'h10, b=8'h20; pulse start with a=8'hAA, b=8'h55 on cycles 3 and 9 (DONE) -> both ignored; single done; sum=8'h30; the previous sum holds until the completion edge.
- Assert rst_n low in ADD cycle 4 of an operation -> busy, done, sum and cout are all 0 immediately; no done pulse; a start after release computes correctly (8'h7F + 8'h01 -> 8'h80, cout=0).
- start held high for 30 cycles with constant a=8'h01, b=8'h02 -> done pulses every 10 cycles, and sum=8'h03 each time.
